spi_cmd_parser: RTL and testbench
=================================

# spi_cmd_parser

Byte-level command decoder that sits directly downstream of the SPI slave byte receiver. It consumes each received byte as a one-cycle `byte_rdy_in` strobe with `byte_data_in`. The first byte of a chip-select transaction is the opcode; following bytes become auto-incrementing configuration-register writes, pixel-RAM writes, or a frame-refresh request. Its outputs drive the LED timing register file and the pixel frame-buffer RAM write port.

## Interface
Parameters:
- `RAM_AW`, 9: pixel RAM address width (byte-addressed; depth 2^RAM_AW).
- `CFG_NUM`, 4: number of configuration registers (1..8).

Ports:
- `clk_in`  in  1  system clock.
- `spi_rst_n`  in  1  reset, asynchronous, active-low. Low whenever chip-select is deasserted or the global reset is low, so each transaction starts from reset.
- `byte_rdy_in`  in  1  one-cycle strobe: `byte_data_in` valid.
- `byte_data_in`  in  8  received byte.
- `cfg_wr_en_out`  out  1  config register write strobe (1 cycle).
- `cfg_wr_addr_out`  out  3  config register index.
- `cfg_wr_data_out`  out  8  config register data.
- `ram_wr_en_out`  out  1  pixel RAM write strobe (1 cycle).
- `ram_wr_addr_out`  out  RAM_AW  pixel RAM byte address.
- `ram_wr_data_out`  out  8  pixel RAM data.
- `refresh_out`  out  1  one-cycle request to start LED frame output.

## Operation
- Opcodes:
  - 0x2A CONF_WR
  - 0x2C DATA_WR
  - 0x2B REFRESH
  - any other value is unknown.
- FSM states: CMD (reset state), CONF, DATA, DISCARD. State changes only on `byte_rdy_in`=1.
- CMD:
  - 0x2A → CONF; internal index counter cleared to 0.
  - 0x2C → DATA; address counter cleared to 0.
  - 0x2B → pulse `refresh_out`, go to DISCARD.
  - other → DISCARD.
- CONF: each byte with index < CFG_NUM:
  - `cfg_wr_en_out`=1, `cfg_wr_addr_out`=index, `cfg_wr_data_out`=byte;
  - index increments (saturating at CFG_NUM).
  - Bytes with index ≥ CFG_NUM are ignored; no strobe. State stays CONF.
- DATA: each byte:
  - `ram_wr_en_out`=1, `ram_wr_addr_out`=addr, `ram_wr_data_out`=byte;
  - addr increments.
  - End-of-RAM behaviour is set by the Configuration section. State stays DATA.
- DISCARD: all bytes ignored until reset.
- Only `spi_rst_n` leaves CONF, DATA or DISCARD. There is no in-band return to CMD.
- Counter widths: index is 4 bits; addr is RAM_AW bits plus one overflow flag.

## Timing
- Reset values: every output is 0. Internal state is CMD, index 0, addr 0, overflow flag 0.
- Latency:
  - A strobe, data and address are registered outputs. They assert in the cycle after the `byte_rdy_in` cycle.
  - They stay high exactly 1 cycle; data and address are valid in that same cycle.
  - `refresh_out` follows the opcode strobe by 1 cycle, lasts 1 cycle.
- Back-to-back `byte_rdy_in` on consecutive cycles is accepted. Each strobe produces one output strobe; there is no throughput limit.
- The opcode byte itself never produces a cfg or RAM write.
- Reset mid-transaction: all outputs drop to 0 immediately (asynchronous). A write strobe pending in the same cycle is lost. The next transaction restarts in CMD.
- `byte_data_in` is sampled only when `byte_rdy_in`=1.

## Configuration
- `SPI_CMD_PARSER_RAM_WRAP_EN` defined: after writing address 2^RAM_AW−1, addr wraps to 0. Writing continues, overwriting from address 0.
- `SPI_CMD_PARSER_RAM_WRAP_EN` undefined: after writing address 2^RAM_AW−1, the overflow flag sets. Further DATA bytes produce no `ram_wr_en_out` until reset.

## Test plan
- CONF_WR, CFG_NUM=4, bytes 0x2A,0x11,0x22,0x33,0x44,0x55 → four `cfg_wr_en_out` pulses with (addr,data) = (0,0x11),(1,0x22),(2,0x33),(3,0x44). No pulse for 0x55. `ram_wr_en_out` never asserts.
- DATA_WR with back-to-back strobes 0x2C,0xA0,0xA1,0xA2 → RAM writes (0,0xA0),(1,0xA1),(2,0xA2) on three consecutive cycles. Each write is 1 cycle after its strobe.
- REFRESH 0x2B then 0x2C,0x99 → exactly one `refresh_out` pulse 1 cycle after the opcode strobe. No RAM write, because the block is in DISCARD.
- Unknown opcode 0x00, then 0x2A,0x01 → no strobes at all. Then deassert reset and send 0x2A,0x01 → cfg write (0,0x01).
- RAM_AW=2, bytes 0x2C then 0x10..0x15:
  - without the macro: writes to addresses 0..3 only;
  - with the macro: addresses 0,1,2,3,0,1 with data 0x10..0x15.
- Reset pulse between the 2nd and 3rd data byte of a DATA_WR → outputs 0 immediately. The following 0x2C,0x77 writes (0,0x77).

Source files
------------

// File: rtl/spi_cmd_parser_if.sv
// Byte-in / register-and-RAM-write-out bundle of the SPI command parser.
interface spi_cmd_parser_if #(parameter int RAM_AW = 9);
  logic              byte_rdy_in;
  logic [7:0]        byte_data_in;
  logic              cfg_wr_en_out;
  logic [2:0]        cfg_wr_addr_out;
  logic [7:0]        cfg_wr_data_out;
  logic              ram_wr_en_out;
  logic [RAM_AW-1:0] ram_wr_addr_out;
  logic [7:0]        ram_wr_data_out;
  logic              refresh_out;

  modport master (
    output byte_rdy_in, byte_data_in,
    input  cfg_wr_en_out, cfg_wr_addr_out, cfg_wr_data_out,
           ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, refresh_out
  );

  modport slave (
    input  byte_rdy_in, byte_data_in,
    output cfg_wr_en_out, cfg_wr_addr_out, cfg_wr_data_out,
           ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, refresh_out
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// SPI byte-stream command decoder: opcode byte, then auto-incrementing cfg/RAM writes or refresh.
// Define SPI_CMD_PARSER_RAM_WRAP_EN to make the RAM address wrap instead of stopping at the end.
module spi_cmd_parser #(
  parameter int RAM_AW  = 9,
  parameter int CFG_NUM = 4
) (
  input  logic              clk_in,
  input  logic              spi_rst_n,
  spi_cmd_parser_if.slave   bus
);

  typedef enum logic [1:0] {CMD, CONF, DATA, DISCARD} state_t;

  localparam logic [7:0] OP_CONF = 8'h2A;
  localparam logic [7:0] OP_DATA = 8'h2C;
  localparam logic [7:0] OP_REFR = 8'h2B;
  localparam logic [3:0] CFG_LIM = 4'(CFG_NUM);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;

  logic              cfg_we_q, cfg_we_d;
  logic [2:0]        cfg_a_q, cfg_a_d;
  logic [7:0]        cfg_d_q, cfg_d_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_d_q, ram_d_d;
  logic              refr_q, refr_d;

  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q  <= CMD;
      idx_q    <= '0;
      addr_q   <= '0;
      ovf_q    <= 1'b0;
      cfg_we_q <= 1'b0;
      cfg_a_q  <= '0;
      cfg_d_q  <= '0;
      ram_we_q <= 1'b0;
      ram_a_q  <= '0;
      ram_d_q  <= '0;
      refr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      cfg_we_q <= cfg_we_d;
      cfg_a_q  <= cfg_a_d;
      cfg_d_q  <= cfg_d_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_d_q  <= ram_d_d;
      refr_q   <= refr_d;
    end
  end

  // Address/data outputs are zeroed outside their strobe cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    cfg_we_d = 1'b0;
    cfg_a_d  = '0;
    cfg_d_d  = '0;
    ram_we_d = 1'b0;
    ram_a_d  = '0;
    ram_d_d  = '0;
    refr_d   = 1'b0;
    if (bus.byte_rdy_in) begin
      case (state_q)
        CMD: begin
          case (bus.byte_data_in)
            OP_CONF: begin
              state_d = CONF;
              idx_d   = '0;
            end
            OP_DATA: begin
              state_d = DATA;
              addr_d  = '0;
              ovf_d   = 1'b0;
            end
            OP_REFR: begin
              state_d = DISCARD;
              refr_d  = 1'b1;
            end
            default: state_d = DISCARD;
          endcase
        end
        CONF: begin
          if (idx_q < CFG_LIM) begin
            cfg_we_d = 1'b1;
            cfg_a_d  = idx_q[2:0];
            cfg_d_d  = bus.byte_data_in;
            idx_d    = idx_q + 4'd1;
          end
        end
        DATA: begin
          if (!ovf_q) begin
            ram_we_d = 1'b1;
            ram_a_d  = addr_q;
            ram_d_d  = bus.byte_data_in;
`ifdef SPI_CMD_PARSER_RAM_WRAP_EN
            addr_d   = addr_q + RAM_AW'(1);
`else
            {ovf_d, addr_d} = {1'b0, addr_q} + (RAM_AW+1)'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_wr_en_out   = cfg_we_q;
  assign bus.cfg_wr_addr_out = cfg_a_q;
  assign bus.cfg_wr_data_out = cfg_d_q;
  assign bus.ram_wr_en_out   = ram_we_q;
  assign bus.ram_wr_addr_out = ram_a_q;
  assign bus.ram_wr_data_out = ram_d_q;
  assign bus.refresh_out     = refr_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Bench for spi_cmd_parser: directed vector table plus random transactions against a count-based model.
module tb_spi_cmd_parser;
  localparam int RAM_AW  = 2;
  localparam int CFG_NUM = 4;

  logic clk_in = 1'b0;
  logic spi_rst_n;
  always #5 clk_in = ~clk_in;

  spi_cmd_parser_if #(.RAM_AW(RAM_AW)) bus();
  spi_cmd_parser #(.RAM_AW(RAM_AW), .CFG_NUM(CFG_NUM)) dut (
    .clk_in(clk_in), .spi_rst_n(spi_rst_n), .bus(bus)
  );

  // Output word: [23] cfg_we [22:20] cfg_a [19:12] cfg_d [11] ram_we [10:9] ram_a [8:1] ram_d [0] refresh
  typedef struct {
    bit         rst;
    bit         rdy;
    logic [7:0] d;
    logic [23:0] e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [23:0] pend;
  vec_t tbl[$];

  // model state
  bit   m_have_op;
  logic [7:0] m_op;
  int   m_n;

  function automatic logic [23:0] ev_cfg(input int a, input logic [7:0] d);
    logic [2:0] aa = 3'(a);
    return {1'b1, aa, d, 12'h0};
  endfunction
  function automatic logic [23:0] ev_ram(input int a, input logic [7:0] d);
    logic [1:0] aa = 2'(a);
    return {12'h0, 1'b1, aa, d, 1'b0};
  endfunction
  localparam logic [23:0] EV_REF  = 24'h000001;
  localparam logic [23:0] EV_NONE = 24'h000000;

  function automatic logic [23:0] outs();
    return {bus.cfg_wr_en_out, bus.cfg_wr_addr_out, bus.cfg_wr_data_out,
            bus.ram_wr_en_out, bus.ram_wr_addr_out, bus.ram_wr_data_out, bus.refresh_out};
  endfunction

  task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step(input string tag, input bit rdy, input logic [7:0] d, input logic [23:0] e);
    @(negedge clk_in);
    chk(tag, outs(), pend);
    bus.byte_rdy_in  = rdy;
    bus.byte_data_in = d;
    pend = e;
  endtask

  // Check the result of the last driven byte, then drop reset while it is still on the outputs.
  task automatic pulse_reset(input string tag);
    @(posedge clk_in);
    #1;
    chk({tag, "_pre"}, outs(), pend);
    spi_rst_n = 1'b0;
    #1;
    chk({tag, "_rst"}, outs(), EV_NONE);
    bus.byte_rdy_in = 1'b0;
    pend = EV_NONE;
    m_have_op = 1'b0;
    m_n = 0;
    @(negedge clk_in);
    spi_rst_n = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [23:0] e);
    e = EV_NONE;
    if (!m_have_op) begin
      m_have_op = 1'b1;
      m_op = b;
      if (b == 8'h2B) e = EV_REF;
    end else begin
      if (m_op == 8'h2A && m_n < CFG_NUM) e = ev_cfg(m_n, b);
      if (m_op == 8'h2C) begin
`ifdef SPI_CMD_PARSER_RAM_WRAP_EN
        e = ev_ram(m_n % (1 << RAM_AW), b);
`else
        if (m_n < (1 << RAM_AW)) e = ev_ram(m_n, b);
`endif
      end
      m_n++;
    end
  endtask

  function automatic void add(input bit rdy, input logic [7:0] d, input logic [23:0] e);
    vec_t v;
    v.rst = 1'b0; v.rdy = rdy; v.d = d; v.e = e;
    tbl.push_back(v);
  endfunction
  function automatic void add_rst();
    vec_t v;
    v.rst = 1'b1; v.rdy = 1'b0; v.d = 8'h0; v.e = EV_NONE;
    tbl.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] e;
    spi_rst_n = 1'b0;
    bus.byte_rdy_in = 1'b0;
    bus.byte_data_in = 8'h00;
    pend = EV_NONE;
    m_have_op = 1'b0;
    m_op = 8'h00;
    m_n = 0;

    // CONF_WR with one byte past CFG_NUM
    add(1, 8'h2A, EV_NONE); add(1, 8'h11, ev_cfg(0, 8'h11)); add(1, 8'h22, ev_cfg(1, 8'h22));
    add(1, 8'h33, ev_cfg(2, 8'h33)); add(1, 8'h44, ev_cfg(3, 8'h44)); add(1, 8'h55, EV_NONE);
    add_rst();
    // DATA_WR back-to-back, then an idle cycle
    add(1, 8'h2C, EV_NONE); add(1, 8'hA0, ev_ram(0, 8'hA0)); add(1, 8'hA1, ev_ram(1, 8'hA1));
    add(1, 8'hA2, ev_ram(2, 8'hA2)); add(0, 8'hA3, EV_NONE);
    add_rst();
    // REFRESH then discarded DATA_WR
    add(1, 8'h2B, EV_REF); add(1, 8'h2C, EV_NONE); add(1, 8'h99, EV_NONE);
    add_rst();
    // idle byte with opcode value, unknown opcode, then a fresh transaction
    add(0, 8'h2C, EV_NONE); add(1, 8'h00, EV_NONE); add(1, 8'h2A, EV_NONE); add(1, 8'h01, EV_NONE);
    add_rst();
    add(1, 8'h2A, EV_NONE); add(1, 8'h01, ev_cfg(0, 8'h01));
    add_rst();
    // end of RAM
    add(1, 8'h2C, EV_NONE);
    add(1, 8'h10, ev_ram(0, 8'h10)); add(1, 8'h11, ev_ram(1, 8'h11));
    add(1, 8'h12, ev_ram(2, 8'h12)); add(1, 8'h13, ev_ram(3, 8'h13));
`ifdef SPI_CMD_PARSER_RAM_WRAP_EN
    add(1, 8'h14, ev_ram(0, 8'h14)); add(1, 8'h15, ev_ram(1, 8'h15));
`else
    add(1, 8'h14, EV_NONE); add(1, 8'h15, EV_NONE);
`endif
    add_rst();
    // reset between 2nd and 3rd data byte
    add(1, 8'h2C, EV_NONE); add(1, 8'hB0, ev_ram(0, 8'hB0)); add(1, 8'hB1, ev_ram(1, 8'hB1));
    add_rst();
    add(1, 8'h2C, EV_NONE); add(1, 8'h77, ev_ram(0, 8'h77));
    add_rst();

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_state", outs(), EV_NONE);
    @(negedge clk_in);
    spi_rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) pulse_reset($sformatf("vec%0d", i));
      else step($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].d, tbl[i].e);
    end

    for (int t = 0; t < 300; t++) begin
      int len = $urandom_range(1, 10);
      int sel = $urandom_range(0, 5);
      logic [7:0] op;
      case (sel)
        0, 1: op = 8'h2A;
        2, 3: op = 8'h2C;
        4:    op = 8'h2B;
        default: op = 8'($urandom);
      endcase
      for (int k = 0; k < len; k++) begin
        bit rdy = ($urandom_range(0, 9) < 7);
        logic [7:0] b = (k == 0) ? op : 8'($urandom);
        if (k == 0) rdy = 1'b1;
        e = EV_NONE;
        if (rdy) model_byte(b, e);
        step($sformatf("rnd%0d_%0d", t, k), rdy, b, e);
      end
      pulse_reset($sformatf("rnd%0d", t));
    end

    step("final", 1'b0, 8'h00, EV_NONE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
